cache_arbiter: RTL and testbench

Arbitrates the single 256-bit physical-memory port between the instruction cache and the data cache of the split-cache memory hierarchy. Accepts whole-line read requests from the I-cache and line read/write-back requests from the D-cache, and grants one at a time with round-robin fairness. Captures the granted request and drives it to physical memory (cacheline adaptor) until `mem_resp`. Routes the response back to the winning cache.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_arbiter.sv | 117 +++++++++++
 tb/tb_cache_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the I/D cache arbiter.
// Holds the arbiter FSM state encoding and bus widths.
package cache_arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I/D caches.
// Ports: I-cache read req/resp, D-cache read/write-back req/resp, mem_* port.
import cache_arb_pkg::*;

module cache_arbiter (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_last_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  always_comb begin
    w_next      = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (r_state)
      IDLE: begin
        // On contention, I wins only if D was served last.
        if (w_i_req && (!w_d_req || r_last_d)) begin
          w_grant_i = 1'b1;
          w_next    = SERVE_I;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
          w_next    = SERVE_D;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          w_next      = RECOVER;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          w_next      = RECOVER;
        end
      end
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_last_d      <= 1'b1;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) begin
        r_last_d      <= 1'b0;
        r_mem_read    <= 1'b1;
        r_mem_write   <= 1'b0;
        r_mem_address <= i_pmem_address;
        r_mem_wdata   <= '0;
      end else if (w_grant_d) begin
        // Illegal read+write collapses to a write.
        r_last_d      <= 1'b1;
        r_mem_read    <= ~d_pmem_write;
        r_mem_write   <= d_pmem_write;
        r_mem_address <= d_pmem_address;
        r_mem_wdata   <= d_pmem_wdata;
      end else if (i_pmem_resp || d_pmem_resp) begin
        r_mem_read    <= 1'b0;
        r_mem_write   <= 1'b0;
      end
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_address  = r_mem_address;
  assign mem_wdata    = r_mem_wdata;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  a_d_rw_exclusive: assert property (
    @(posedge clk) disable iff (!rst)
    !(d_pmem_read && d_pmem_write)
  ) else $warning("cache_arbiter: D read+write both high, write wins");

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a cycle-level reference model.
// Drives cache/memory stimulus and checks outputs every cycle.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int checks;
  int failures;

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 I, 2 D), how many
  // quiet edges remain before a new grant, and who went last.
  int           m_owner;
  int           m_cool;
  bit           m_last_d;
  logic         e_read;
  logic         e_write;
  logic [31:0]  e_addr;
  logic [255:0] e_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner  = 0;
      m_cool   = 0;
      m_last_d = 1'b1;
      e_read   = 1'b0;
      e_write  = 1'b0;
      e_addr   = '0;
      e_wdata  = '0;
    end else if (m_owner != 0) begin
      if (mem_resp) begin
        m_owner = 0;
        m_cool  = 1;
        e_read  = 1'b0;
        e_write = 1'b0;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      bit iq, dq;
      iq = i_pmem_read;
      dq = d_pmem_read | d_pmem_write;
      if (iq && (!dq || m_last_d)) begin
        m_owner  = 1;
        m_last_d = 1'b0;
        e_read   = 1'b1;
        e_write  = 1'b0;
        e_addr   = i_pmem_address;
      end else if (dq) begin
        m_owner  = 2;
        m_last_d = 1'b1;
        e_write  = d_pmem_write;
        e_read   = !d_pmem_write;
        e_addr   = d_pmem_address;
        e_wdata  = d_pmem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("mem_read", mem_read, e_read);
      chk("mem_write", mem_write, e_write);
      chk("i_resp", i_pmem_resp,
          (m_owner == 1) && mem_resp);
      chk("d_resp", d_pmem_resp,
          (m_owner == 2) && mem_resp);
      if (e_read || e_write)
        chk("mem_address", mem_address, e_addr);
      if (e_write)
        chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  // Waits for a grant, answers after lat cycles, reports the winner
  // and drops the winner's request once its resp has been seen.
  task automatic serve(input int lat,
                       input logic [255:0] data,
                       output int who,
                       output int wcyc,
                       output logic [31:0] g_addr,
                       output logic g_rd,
                       output logic g_wr);
    int n;
    who = 0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(mem_read || mem_write) && n < 20);
    wcyc   = n;
    g_addr = mem_address;
    g_rd   = mem_read;
    g_wr   = mem_write;
    chk("grant_seen", mem_read | mem_write, 1'b1);
    if (!(mem_read || mem_write)) return;
    repeat (lat - 1) begin
      @(posedge clk); #1;
    end
    mem_rdata = data;
    mem_resp  = 1'b1;
    #1;
    if (i_pmem_resp) who = 1;
    else if (d_pmem_resp) who = 2;
    chk("resp_rdata",
        (who == 1) ? i_pmem_rdata : d_pmem_rdata, data);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    if (who == 1) i_pmem_read = 1'b0;
    if (who == 2) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  int           who;
  int           wc;
  logic [31:0]  ga;
  logic         grd;
  logic         gwr;
  logic [255:0] line_a5;
  logic [255:0] wd;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    i_pmem_read = 1'b0;
    i_pmem_address = '0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata = '0;
    mem_rdata = '0;
    mem_resp = 1'b0;
    line_a5 = {32{8'hA5}};
    #2;
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Lone I read
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_0060;
    serve(5, line_a5, who, wc, ga, grd, gwr);
    chk("loneI_who", who, 1);
    chk("loneI_latency", wc, 1);
    chk("loneI_addr", ga, 32'h60);
    chk("loneI_rd", grd, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // D write-back
    wd = {8{32'h1234_5678}};
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_1000;
    d_pmem_wdata = wd;
    serve(3, '0, who, wc, ga, grd, gwr);
    chk("wb_who", who, 2);
    chk("wb_addr", ga, 32'h1000);
    chk("wb_wr", gwr, 1'b1);
    @(posedge clk); #1;
    chk("wb_recover_idle", mem_write, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset then contention: I, D, I
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0200;
    serve(2, {8{32'h1111_0000}}, who, wc, ga, grd, gwr);
    chk("cont1_who", who, 1);
    i_pmem_read = 1'b1;
    serve(2, {8{32'h2222_0000}}, who, wc, ga, grd, gwr);
    chk("cont2_who", who, 2);
    chk("cont2_gap", wc, 2);
    d_pmem_read = 1'b1;
    serve(2, {8{32'h3333_0000}}, who, wc, ga, grd, gwr);
    chk("cont3_who", who, 1);
    d_pmem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // D read dropped after one cycle of service
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0040;
    fork
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_pmem_read = 1'b0;
      end
    join_none
    serve(4, {8{32'hDEAD_BEEF}}, who, wc, ga, grd, gwr);
    chk("drop_who", who, 2);
    chk("drop_addr", ga, 32'h40);
    repeat (3) @(posedge clk);
    #1;

    // Reset during SERVE_D
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_2000;
    d_pmem_wdata = {8{32'hCAFE_F00D}};
    @(posedge clk); #1;
    chk("pre_rst_write", mem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_write", mem_write, 1'b0);
    chk("async_addr", mem_address, 32'h0);
    d_pmem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    i_pmem_read = 1'b1;
    i_pmem_address = 32'h0000_0300;
    d_pmem_read = 1'b1;
    d_pmem_address = 32'h0000_0400;
    serve(2, {8{32'h0F0F_0F0F}}, who, wc, ga, grd, gwr);
    chk("post_rst_who", who, 1);
    serve(2, {8{32'hF0F0_F0F0}}, who, wc, ga, grd, gwr);
    chk("post_rst_who2", who, 2);
    repeat (3) @(posedge clk);
    #1;

    // Stray resp in IDLE
    mem_resp = 1'b1;
    mem_rdata = line_a5;
    #1;
    chk("stray_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    chk("stray_idle", mem_read | mem_write, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Illegal D read+write: write wins
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_0080;
    d_pmem_wdata = {32{8'h3C}};
    serve(2, '0, who, wc, ga, grd, gwr);
    chk("illegal_who", who, 2);
    chk("illegal_wr", gwr, 1'b1);
    chk("illegal_rd", grd, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
